// File: rtl/edit_digit_cursor_pkg.sv
// Shared types and slot arithmetic for the front-panel edit cursor.
package edit_digit_cursor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // A slot is usable when its position inside its group is below the used count.
  function automatic logic is_legal(int d, int group, int used);
    return (d % group) < used;
  endfunction

  // Next usable slot, wrapping from the highest usable slot back to 0.
  function automatic int next_legal(int d, int num, int group, int used);
    int last;
    int n;
    last = num - group + used - 1;
    if (d >= last) return 0;
    n = d + 1;
    if (!is_legal(n, group, used)) n = n + group - (n % group);
    return n;
  endfunction

  // Previous usable slot, wrapping from 0 to the highest usable slot.
  function automatic int prev_legal(int d, int num, int group, int used);
    int p;
    if (d == 0) return num - group + used - 1;
    p = d - 1;
    if (!is_legal(p, group, used)) p = p - (p % group) + used - 1;
    return p;
  endfunction

endpackage

// File: rtl/edit_cursor_pos.sv
// Cursor position register with next/prev stepping over usable slots.
module edit_cursor_pos
  import edit_digit_cursor_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 32,
  parameter int unsigned GROUP          = 4,
  parameter int unsigned USED_PER_GROUP = 3,
  parameter int unsigned DW             = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cursorNext,
  input  logic          cursorPrev,
  output logic [DW-1:0] digit,
  output logic          move_c
);

  logic [DW-1:0] digit_nxt;

  // Step direction decode; opposing requests cancel out.
  always_comb begin
    move_c    = cursorNext ^ cursorPrev;
    digit_nxt = digit;
    if (move_c) begin
      if (cursorNext)
        digit_nxt = DW'(next_legal(int'(digit), int'(NUM_DIGITS), int'(GROUP), int'(USED_PER_GROUP)));
      else
        digit_nxt = DW'(prev_legal(int'(digit), int'(NUM_DIGITS), int'(GROUP), int'(USED_PER_GROUP)));
    end
  end

  // Cursor register.
  always_ff @(posedge clk) begin
    if (reset) digit <= '0;
    else       digit <= digit_nxt;
  end

endmodule

// File: rtl/edit_digit_cursor.sv
// Edit cursor plus inc/dec pulse generator with hold-to-repeat.
module edit_digit_cursor
  import edit_digit_cursor_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 32,
  parameter int unsigned GROUP          = 4,
  parameter int unsigned USED_PER_GROUP = 3,
  parameter int unsigned FAST_DIGITS    = 6,
  parameter int unsigned HOLD_TICKS     = 4,
  parameter int unsigned REPEAT_DIV     = 8,
  localparam int unsigned DW            = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cursorNext,
  input  logic                  cursorPrev,
  input  logic                  incSelection,
  input  logic                  decSelection,
  input  logic                  slow_clock,
  output logic [DW-1:0]         digit,
  output logic [NUM_DIGITS-1:0] doInc,
  output logic [NUM_DIGITS-1:0] doDec,
  output logic                  repeating
);

  localparam int unsigned TW = $clog2(HOLD_TICKS + 1);
  localparam int unsigned VW = $clog2(REPEAT_DIV + 1);

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [VW-1:0] div_q, div_d;
  logic          dir_q, dir_d;
  logic          move_c;
  logic          req_c, dir_c, abort_c, fire_c;
  logic          pend_valid_q, pend_dir_q;
  logic [DW-1:0] pend_digit_q;

  edit_cursor_pos #(
    .NUM_DIGITS    (NUM_DIGITS),
    .GROUP         (GROUP),
    .USED_PER_GROUP(USED_PER_GROUP),
    .DW            (DW)
  ) u_pos (
    .clk       (clk),
    .reset     (reset),
    .cursorNext(cursorNext),
    .cursorPrev(cursorPrev),
    .digit     (digit),
    .move_c    (move_c)
  );

  // Request FSM: first pulse on press, hold count, then periodic repeat.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    div_d   = div_q;
    dir_d   = dir_q;
    fire_c  = 1'b0;
    req_c   = incSelection ^ decSelection;
    dir_c   = incSelection;
    abort_c = !req_c || (dir_c != dir_q) || move_c;
    case (state_q)
      IDLE: begin
        if (req_c && !move_c) begin
          fire_c  = 1'b1;
          dir_d   = dir_c;
          tick_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (abort_c) begin
          tick_d  = '0;
          state_d = IDLE;
        end else if (slow_clock) begin
          if (tick_q == TW'(HOLD_TICKS - 1)) begin
            fire_c  = 1'b1;
            div_d   = '0;
            tick_d  = '0;
            state_d = REPEAT;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      REPEAT: begin
        if (abort_c) begin
          div_d   = '0;
          state_d = IDLE;
        end else if (slow_clock) begin
          if (32'(digit) < FAST_DIGITS) begin
            fire_c = 1'b1;
          end else if (div_q == VW'(REPEAT_DIV - 1)) begin
            fire_c = 1'b1;
            div_d  = '0;
          end else begin
            div_d = div_q + VW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, counters and the repeating flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      div_q     <= '0;
      dir_q     <= 1'b0;
      repeating <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      div_q     <= div_d;
      dir_q     <= dir_d;
      repeating <= (state_d == REPEAT);
    end
  end

  // Capture the pulse decision together with the digit sampled at that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_dir_q   <= 1'b0;
      pend_digit_q <= '0;
    end else begin
      pend_valid_q <= fire_c;
      pend_dir_q   <= dir_c;
      pend_digit_q <= digit;
    end
  end

  // One-hot output pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      doInc <= '0;
      doDec <= '0;
    end else begin
      doInc <= (pend_valid_q && pend_dir_q)  ? (NUM_DIGITS'(1) << pend_digit_q) : '0;
      doDec <= (pend_valid_q && !pend_dir_q) ? (NUM_DIGITS'(1) << pend_digit_q) : '0;
    end
  end

endmodule

// File: tb/tb_edit_digit_cursor.sv
// Scoreboard bench for edit_digit_cursor with a behavioural press/tick model.
module tb_edit_digit_cursor;

  localparam int ND = 32;
  localparam int GR = 4;
  localparam int UP = 3;
  localparam int FD = 6;
  localparam int HT = 4;
  localparam int RD = 8;
  localparam int DW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cursorNext = 1'b0, cursorPrev = 1'b0;
  logic          incSelection = 1'b0, decSelection = 1'b0;
  logic          slow_clock = 1'b0;
  logic [DW-1:0] digit;
  logic [ND-1:0] doInc, doDec;
  logic          repeating;

  typedef struct {
    int          vis;
    logic [ND-1:0] inc_v;
    logic [ND-1:0] dec_v;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   edge_n = 0;
  bit   mon_en = 0;
  bit   chk_en = 0;

  // Model state: cursor as an index into the list of usable slots,
  // press state as "active" plus ticks seen since the press.
  int legal[$];
  int idx = 0;
  bit active = 0;
  bit ldir = 0;
  int k = 0;
  bit rep = 0;

  edit_digit_cursor dut (
    .clk         (clk),
    .reset       (reset),
    .cursorNext  (cursorNext),
    .cursorPrev  (cursorPrev),
    .incSelection(incSelection),
    .decSelection(decSelection),
    .slow_clock  (slow_clock),
    .digit       (digit),
    .doInc       (doInc),
    .doDec       (doDec),
    .repeating   (repeating)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n = edge_n + 1;

  function automatic void push_pulse(int vis, bit d, int dg);
    exp_t e;
    e.vis   = vis;
    e.inc_v = '0;
    e.dec_v = '0;
    if (d) e.inc_v[dg] = 1'b1;
    else   e.dec_v[dg] = 1'b1;
    q.push_back(e);
  endfunction

  // One clock cycle: check model state, drive inputs, advance the model.
  task automatic step(input bit rs, input bit nx, input bit pv,
                      input bit inc, input bit dec, input bit tk);
    int  e_next;
    int  cur;
    bit  mv, rq, dr;
    @(negedge clk);
    if (chk_en) begin
      vectors += 2;
      if (digit !== DW'(legal[idx])) begin
        miscompares++;
        $display("FAIL digit @edge %0d: got %0d, required %0d", edge_n, digit, legal[idx]);
      end
      if (repeating !== rep) begin
        miscompares++;
        $display("FAIL repeating @edge %0d: got %0b, required %0b", edge_n, repeating, rep);
      end
    end
    reset = rs; cursorNext = nx; cursorPrev = pv;
    incSelection = inc; decSelection = dec; slow_clock = tk;
    e_next = edge_n + 1;
    if (rs) begin
      while (q.size() > 0 && q[q.size()-1].vis >= e_next) void'(q.pop_back());
      active = 0; k = 0; idx = 0; rep = 0;
    end else begin
      mv  = nx ^ pv;
      rq  = inc ^ dec;
      dr  = inc;
      cur = legal[idx];
      if (active) begin
        if (!rq || dr != ldir || mv) begin
          active = 0;
        end else if (tk) begin
          k++;
          if (k == HT || (k > HT && (cur < FD || (k - HT) % RD == 0)))
            push_pulse(e_next + 1, dr, cur);
        end
      end else if (rq && !mv) begin
        active = 1; ldir = dr; k = 0;
        push_pulse(e_next + 1, dr, cur);
      end
      if (mv) idx = nx ? (idx + 1) % legal.size() : (idx + legal.size() - 1) % legal.size();
      rep = active && (k >= HT);
    end
  endtask

  task automatic expect_digit(input string nm, input int v);
    vectors++;
    if (digit !== DW'(v)) begin
      miscompares++;
      $display("FAIL %s: got digit=%0d, required %0d", nm, digit, v);
    end
  endtask

  // Monitor: every pulse seen must match the head of the scoreboard.
  always @(negedge clk) begin : mon_blk
    exp_t e;
    if (mon_en) begin
      while (q.size() > 0 && q[0].vis < edge_n) begin
        vectors++;
        miscompares++;
        $display("FAIL pulse_missing @edge %0d: got none, required inc=%h dec=%h",
                 q[0].vis, q[0].inc_v, q[0].dec_v);
        void'(q.pop_front());
      end
      if (doInc !== '0 || doDec !== '0) begin
        vectors++;
        if (q.size() == 0 || q[0].vis != edge_n) begin
          miscompares++;
          $display("FAIL pulse_unexpected @edge %0d: got inc=%h dec=%h, required none",
                   edge_n, doInc, doDec);
        end else begin
          e = q.pop_front();
          if (doInc !== e.inc_v || doDec !== e.dec_v) begin
            miscompares++;
            $display("FAIL pulse_value @edge %0d: got inc=%h dec=%h, required inc=%h dec=%h",
                     edge_n, doInc, doDec, e.inc_v, e.dec_v);
          end
        end
      end
    end
  end

  initial begin
    bit ri, rd, nx, pv, tk, rs;
    for (int d = 0; d < ND; d++) if (d % GR < UP) legal.push_back(d);

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk_en = 1; mon_en = 1;

    // Cursor stepping and wrap
    for (int i = 0; i < 3; i++) begin step(0, 1, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0); end
    expect_digit("next_x3", 4);
    for (int i = 0; i < 20; i++) begin step(0, 1, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0); end
    expect_digit("next_x23", 30);
    step(0, 1, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
    expect_digit("next_wrap", 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
    expect_digit("prev_wrap", 30);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    expect_digit("both_moves", 30);

    // Single press on digit 2
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);

    // Fast digit 1, dec held, tick every 10 cycles
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 80; i++) step(0, 0, 0, 0, 1, (i % 10) == 9);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

    // Slow digit 8, inc held for 21 ticks
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 210; i++) step(0, 0, 0, 1, 0, (i % 10) == 9);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

    // Repeat on digit 4 interrupted by each abort cause
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, (i % 3) == 2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, (i % 3) == 2);
    step(0, 1, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, (i % 3) == 2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, (i % 3) == 2);
    step(0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

    // Randomised traffic
    ri = 0; rd = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 3))
          0: begin ri = 0; rd = 0; end
          1: begin ri = 1; rd = 0; end
          2: begin ri = 0; rd = 1; end
          default: begin ri = 1; rd = 1; end
        endcase
      end
      nx = ($urandom_range(0, 39) == 0);
      pv = ($urandom_range(0, 39) == 0);
      tk = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 599) == 0);
      step(rs, nx, pv, ri, rd, tk);
    end

    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pulses outstanding, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
